// File: rtl/corelet_feeder_pkg.sv
// corelet_feeder_pkg: FSM states, inst_corelet field layout and beat constants
// shared by the corelet feeder and its arbiter.
package corelet_feeder_pkg;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_BEAT, S_ACK} state_t;

    localparam int BEAT_VALID     = 0;
    localparam int LANE_LSB       = 1;
    localparam int LAST           = 3;
    localparam int LANE_W         = 2;
    localparam int BEATS_PER_WORD = 4;

    function automatic logic [15:0] make_inst(input logic last, input logic [LANE_W-1:0] lane);
        logic [15:0] v;
        v                     = '0;
        v[BEAT_VALID]         = 1'b1;
        v[LANE_LSB +: LANE_W] = lane;
        v[LAST]               = last;
        return v;
    endfunction

endpackage

// File: rtl/corelet_feeder_rr_arb4.sv
// rr_arb4: 4-way round-robin arbiter; priority starts at the lane after last_served.
module rr_arb4
    import corelet_feeder_pkg::*;
(
    input  logic [3:0]        i_req,
    input  logic [LANE_W-1:0] i_last_served,
    output logic [3:0]        o_grant,
    output logic [LANE_W-1:0] o_lane,
    output logic              o_valid
);

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_lane  = '0;
        o_valid = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (i_req[i_last_served + LANE_W'(k)]) begin
                o_lane  = i_last_served + LANE_W'(k);
                o_valid = 1'b1;
            end
        end
        o_grant = o_valid ? 4'b0001 << o_lane : 4'b0000;
    end

endmodule

// File: rtl/corelet_feeder.sv
// corelet_feeder: serves 4 corelet lanes, streaming LEN_NIJ SRAM words per burst as 32-bit beats.
// Define CORELET_FEEDER_PREFETCH_EN to overlap the next word's read with the current word's beats.
module corelet_feeder
    import corelet_feeder_pkg::*;
#(
    parameter int LEN_NIJ  = 16,
    parameter int ADDR_W   = 11,
    parameter int NUM_LANE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LANE-1:0] req,
    output logic [NUM_LANE-1:0] ack,
    output logic [31:0]         in_corelet,
    output logic [15:0]         inst_corelet,
    output logic                mem_cen,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_a,
    input  logic [127:0]        mem_q,
    output logic                busy
);

`ifdef CORELET_FEEDER_PREFETCH_EN
    localparam logic PREFETCH = 1'b1;
`else
    localparam logic PREFETCH = 1'b0;
`endif
    localparam int CNT_W  = (LEN_NIJ > 1) ? $clog2(LEN_NIJ) : 1;
    localparam int BEAT_W = $clog2(BEATS_PER_WORD);

    state_t              r_state, w_next;
    logic [LANE_W-1:0]   r_lane, r_last_served, w_gnt_lane;
    logic [NUM_LANE-1:0] r_gnt, w_gnt;
    logic                w_gnt_valid;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [127:0]        r_shift;
    logic [ADDR_W-1:0]   r_ptr [NUM_LANE];
    logic                w_last_word, w_beat3, w_pf_rd, w_rd;

    rr_arb4 u_arb (
        .i_req        (req),
        .i_last_served(r_last_served),
        .o_grant      (w_gnt),
        .o_lane       (w_gnt_lane),
        .o_valid      (w_gnt_valid)
    );

    assign w_last_word = r_word_cnt == CNT_W'(LEN_NIJ - 1);
    assign w_beat3     = r_beat_cnt == BEAT_W'(BEATS_PER_WORD - 1);
    // Prefetch reads word n+1 on beat 1; the SRAM holds q until the beat-3 capture.
    assign w_pf_rd     = PREFETCH && r_state == S_BEAT && r_beat_cnt == BEAT_W'(1) && !w_last_word;
    assign w_rd        = r_state == S_RD || w_pf_rd;
    assign mem_cen     = !w_rd;
    assign mem_wen     = 1'b1;
    assign mem_a       = w_rd ? r_ptr[r_lane] + ADDR_W'(r_word_cnt) + ADDR_W'(w_pf_rd) : '0;
    assign ack         = r_state == S_ACK ? r_gnt : '0;
    assign busy        = r_state != S_IDLE;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_gnt_valid ? S_RD : S_IDLE;
            S_RD:    w_next = S_CAP;
            S_CAP:   w_next = S_BEAT;
            S_BEAT:  w_next = !w_beat3 ? S_BEAT : w_last_word ? S_ACK : PREFETCH ? S_BEAT : S_RD;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lane        <= '0;
            r_gnt         <= '0;
            r_last_served <= LANE_W'(NUM_LANE - 1);
            r_word_cnt    <= '0;
            r_beat_cnt    <= '0;
            r_shift       <= '0;
            in_corelet    <= '0;
            inst_corelet  <= '0;
            for (int i = 0; i < NUM_LANE; i++) r_ptr[i] <= ADDR_W'(i * LEN_NIJ);
        end else begin
            inst_corelet <= r_state == S_BEAT ? make_inst(w_beat3 && w_last_word, r_lane) : '0;
            if (r_state == S_BEAT) in_corelet <= r_shift[31:0];
            if (r_state == S_IDLE && w_gnt_valid) begin
                r_lane     <= w_gnt_lane;
                r_gnt      <= w_gnt;
                r_word_cnt <= '0;
            end
            if (r_state == S_CAP) begin
                r_shift    <= mem_q;
                r_beat_cnt <= '0;
            end
            if (r_state == S_BEAT) begin
                r_shift    <= (PREFETCH && w_beat3) ? mem_q : r_shift >> 32;
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                if (w_beat3 && !w_last_word) r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
            if (r_state == S_ACK) begin
                r_ptr[r_lane] <= r_ptr[r_lane] + ADDR_W'(BEATS_PER_WORD * LEN_NIJ);
                r_last_served <= r_lane;
            end
        end
    end

endmodule

// File: tb/tb_corelet_feeder.sv
// tb_corelet_feeder: randomized bench checking beats, SRAM addresses and acks
// against a burst-level model of the feeder.
module tb_corelet_feeder;

    localparam int LEN_NIJ = 16;
    localparam int WORDS   = 2048;
`ifdef CORELET_FEEDER_PREFETCH_EN
    localparam int ACK_CYC  = 67;
    localparam int EXP_GAPS = 0;
`else
    localparam int ACK_CYC  = 97;
    localparam int EXP_GAPS = 15;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   req = '0;
    logic [3:0]   ack;
    logic [31:0]  in_corelet;
    logic [15:0]  inst_corelet;
    logic         mem_cen, mem_wen;
    logic [10:0]  mem_a;
    logic [127:0] mem_q = '0;
    logic         busy;
    logic [127:0] sram [WORDS];

    int tests = 0;
    int failed = 0;

    int          m_ptr [4];
    int          m_last;
    logic [31:0] exp_data[$];
    logic [15:0] exp_inst[$];
    logic [10:0] exp_addr[$];

    logic [31:0] obs_data[$];
    logic [15:0] obs_inst[$];
    logic [10:0] obs_addr[$];
    int          obs_gaps[$];
    logic [3:0]  obs_ack, obs_ack_after;
    int          obs_first, obs_ack_cyc;
    bit          obs_timeout;

    corelet_feeder dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .ack         (ack),
        .in_corelet  (in_corelet),
        .inst_corelet(inst_corelet),
        .mem_cen     (mem_cen),
        .mem_wen     (mem_wen),
        .mem_a       (mem_a),
        .mem_q       (mem_q),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!mem_cen) mem_q <= sram[mem_a];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_ptr[i] = i * LEN_NIJ;
        m_last = 3;
    endtask

    function automatic int model_pick(logic [3:0] r);
        for (int k = 1; k <= 4; k++) if (r[(m_last + k) % 4]) return (m_last + k) % 4;
        return -1;
    endfunction

    task automatic model_burst(int lane);
        int a;
        logic [127:0] word;
        exp_data.delete(); exp_inst.delete(); exp_addr.delete();
        for (int w = 0; w < LEN_NIJ; w++) begin
            a = (m_ptr[lane] + w) % WORDS;
            exp_addr.push_back(11'(a));
            word = sram[a];
            for (int b = 0; b < 4; b++) begin
                exp_data.push_back(word[32*b +: 32]);
                exp_inst.push_back(16'(1 + 2 * lane + ((w == LEN_NIJ - 1 && b == 3) ? 8 : 0)));
            end
        end
        m_ptr[lane] = (m_ptr[lane] + 4 * LEN_NIJ) % WORDS;
        m_last = lane;
    endtask

    function automatic int beat_errs();
        int e = (obs_data.size() != exp_data.size()) ? 1 : 0;
        foreach (exp_data[i])
            if (i >= obs_data.size() || obs_data[i] !== exp_data[i] || obs_inst[i] !== exp_inst[i]) e++;
        return e;
    endfunction

    function automatic int addr_errs();
        int e = (obs_addr.size() != exp_addr.size()) ? 1 : 0;
        foreach (exp_addr[i]) if (i >= obs_addr.size() || obs_addr[i] !== exp_addr[i]) e++;
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Watches one burst from the current negedge; on ack, drives nreq, then samples one more cycle.
    task automatic observe(input int drop_at, input logic [3:0] nreq);
        int cyc, gap;
        bit got;
        obs_data.delete(); obs_inst.delete(); obs_addr.delete(); obs_gaps.delete();
        obs_first = -1; obs_ack = '0; obs_ack_after = '0; obs_ack_cyc = -1;
        gap = 0; got = 0; cyc = 0;
        while (!got && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!mem_cen) obs_addr.push_back(mem_a);
            if (inst_corelet[0]) begin
                if (obs_first < 0) obs_first = cyc;
                if (gap > 0) obs_gaps.push_back(gap);
                gap = 0;
                obs_data.push_back(in_corelet);
                obs_inst.push_back(inst_corelet);
                if (obs_data.size() == drop_at) req = '0;
            end else if (obs_first >= 0) gap++;
            if (ack !== 4'b0000) begin
                got = 1; obs_ack = ack; obs_ack_cyc = cyc; req = nreq;
            end
        end
        obs_timeout = !got;
        if (got) begin
            @(negedge clk);
            obs_ack_after = ack;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        tests++; if (ack !== 4'b0) begin failed++; $display("FAIL reset_ack got %h want 0", ack); end
        tests++; if (in_corelet !== 32'b0) begin failed++; $display("FAIL reset_in got %h want 0", in_corelet); end
        tests++; if (inst_corelet !== 16'b0) begin failed++; $display("FAIL reset_inst got %h want 0", inst_corelet); end
        tests++; if (mem_cen !== 1'b1) begin failed++; $display("FAIL reset_cen got %b want 1", mem_cen); end
        tests++; if (mem_wen !== 1'b1) begin failed++; $display("FAIL reset_wen got %b want 1", mem_wen); end
        tests++; if (mem_a !== 11'b0) begin failed++; $display("FAIL reset_mem_a got %h want 0", mem_a); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        int e;
        sram[0] = 128'h0000000D_0000000C_0000000B_0000000A;
        @(negedge clk);
        req = 4'b0001;
        model_burst(model_pick(req));
        observe(-1, 4'b0001);
        tests++; if (obs_timeout) begin failed++; $display("FAIL single_timeout got no ack want ack"); end
        tests++; if (obs_first != 4) begin failed++; $display("FAIL single_latency got %0d want 4", obs_first); end
        tests++;
        if (obs_data.size() < 4 || obs_data[0] !== 32'hA || obs_data[1] !== 32'hB ||
            obs_data[2] !== 32'hC || obs_data[3] !== 32'hD) begin
            failed++; $display("FAIL single_first_word got %0d beats want A,B,C,D", obs_data.size());
        end
        tests++; if (obs_inst.size() == 0 || obs_inst[0] !== 16'h0001) begin failed++; $display("FAIL single_inst0 want 0001"); end
        tests++; if (obs_inst.size() != 64 || obs_inst[63] !== 16'h0009) begin failed++; $display("FAIL single_last got %0d beats want 64 ending 0009", obs_inst.size()); end
        e = beat_errs();
        tests++; if (e != 0) begin failed++; $display("FAIL single_beats got %0d bad beats want 0", e); end
        e = addr_errs();
        tests++; if (e != 0) begin failed++; $display("FAIL single_addr got %0d bad reads want 0", e); end
        tests++; if (obs_ack !== 4'b0001) begin failed++; $display("FAIL single_ack got %b want 0001", obs_ack); end
        tests++; if (obs_ack_after !== 4'b0000) begin failed++; $display("FAIL single_ack_len got %b want 0000", obs_ack_after); end
        tests++; if (obs_ack_cyc != ACK_CYC) begin failed++; $display("FAIL single_ack_cyc got %0d want %0d", obs_ack_cyc, ACK_CYC); end
        e = 0;
        foreach (obs_gaps[i]) if (obs_gaps[i] != 2) e++;
        tests++; if (obs_gaps.size() != EXP_GAPS || e != 0) begin failed++; $display("FAIL single_gaps got %0d gaps (%0d not 2) want %0d", obs_gaps.size(), e, EXP_GAPS); end
        model_burst(model_pick(4'b0001));
        observe(-1, 4'b0000);
        tests++; if (obs_addr.size() == 0 || obs_addr[0] !== 11'd64) begin failed++; $display("FAIL single_ptr_advance want first read 64"); end
        e = beat_errs();
        tests++; if (e != 0) begin failed++; $display("FAIL single_second_beats got %0d bad want 0", e); end
    endtask

    task automatic test_round_robin();
        int e;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            model_burst(model_pick(req));
            observe(-1, i == 4 ? 4'b0000 : 4'b1111);
            tests++; if (obs_ack !== 4'(1 << (i % 4))) begin failed++; $display("FAIL rr_ack[%0d] got %b want lane %0d", i, obs_ack, i % 4); end
            tests++; if (obs_inst.size() == 0 || obs_inst[0][2:1] !== 2'(i % 4)) begin failed++; $display("FAIL rr_lane[%0d] want lane %0d", i, i % 4); end
            e = beat_errs();
            tests++; if (e != 0) begin failed++; $display("FAIL rr_beats[%0d] got %0d bad want 0", i, e); end
        end
    endtask

    task automatic test_wrap();
        int e;
        logic [10:0] a31_first, a31_last, a32_first;
        e = 0; a31_first = 'x; a31_last = 'x; a32_first = 'x;
        do_reset();
        req = 4'b1000;
        for (int b = 0; b < 33; b++) begin
            model_burst(model_pick(req));
            observe(-1, b == 32 ? 4'b0000 : 4'b1000);
            e += beat_errs() + addr_errs() + ((obs_ack !== 4'b1000) ? 1 : 0);
            if (b == 31 && obs_addr.size() == 16) begin a31_first = obs_addr[0]; a31_last = obs_addr[15]; end
            if (b == 32 && obs_addr.size() > 0) a32_first = obs_addr[0];
        end
        tests++; if (e != 0) begin failed++; $display("FAIL wrap_bursts got %0d errors want 0", e); end
        tests++; if (a31_first !== 11'd2032 || a31_last !== 11'd2047) begin failed++; $display("FAIL wrap_top got %0d..%0d want 2032..2047", a31_first, a31_last); end
        tests++; if (a32_first !== 11'd48) begin failed++; $display("FAIL wrap_around got %0d want 48", a32_first); end
    endtask

    task automatic test_reset_mid();
        int n, cyc, e;
        bit saw_ack;
        n = 0; cyc = 0; saw_ack = 0;
        do_reset();
        req = 4'b0001;
        while (n < 20 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (inst_corelet[0]) n++;
            if (ack !== 4'b0) saw_ack = 1;
        end
        tests++; if (n != 20) begin failed++; $display("FAIL mid_reach_beat got %0d beats want 20", n); end
        reset = 1'b0;
        #1;
        tests++; if (in_corelet !== 32'b0 || inst_corelet !== 16'b0) begin failed++; $display("FAIL mid_outputs got %h/%h want 0/0", in_corelet, inst_corelet); end
        tests++; if (mem_cen !== 1'b1 || mem_a !== 11'b0 || busy !== 1'b0) begin failed++; $display("FAIL mid_ctrl got cen=%b a=%h busy=%b want 1/0/0", mem_cen, mem_a, busy); end
        tests++; if (ack !== 4'b0 || saw_ack) begin failed++; $display("FAIL mid_no_ack got %b seen=%0d want 0", ack, saw_ack); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        model_burst(model_pick(req));
        observe(-1, 4'b0000);
        tests++; if (obs_addr.size() == 0 || obs_addr[0] !== 11'd0) begin failed++; $display("FAIL mid_restart want first read 0"); end
        e = beat_errs();
        tests++; if (e != 0 || obs_ack !== 4'b0001) begin failed++; $display("FAIL mid_rerun got %0d bad ack=%b want 0/0001", e, obs_ack); end
    endtask

    task automatic test_drop_req();
        int e;
        bit busy_seen;
        busy_seen = 0;
        do_reset();
        req = 4'b0100;
        model_burst(model_pick(req));
        observe(10, 4'b0000);
        tests++; if (obs_timeout || obs_ack !== 4'b0100) begin failed++; $display("FAIL drop_ack got %b want 0100", obs_ack); end
        tests++; if (obs_ack_after !== 4'b0000) begin failed++; $display("FAIL drop_ack_len got %b want 0000", obs_ack_after); end
        e = beat_errs();
        tests++; if (e != 0) begin failed++; $display("FAIL drop_beats got %0d bad want 0", e); end
        repeat (8) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen = 1;
        end
        tests++; if (busy_seen) begin failed++; $display("FAIL drop_idle got busy want idle"); end
    endtask

    task automatic test_random();
        int lane, e;
        logic [3:0] nr;
        do_reset();
        req = 4'($urandom_range(1, 15));
        for (int i = 0; i < 12; i++) begin
            lane = model_pick(req);
            model_burst(lane);
            nr = (i == 11) ? 4'b0000 : 4'($urandom_range(1, 15));
            observe(-1, nr);
            tests++; if (obs_ack !== 4'(1 << lane)) begin failed++; $display("FAIL rand_ack[%0d] got %b want lane %0d", i, obs_ack, lane); end
            e = beat_errs();
            tests++; if (e != 0) begin failed++; $display("FAIL rand_beats[%0d] got %0d bad want 0", i, e); end
            e = addr_errs();
            tests++; if (e != 0) begin failed++; $display("FAIL rand_addr[%0d] got %0d bad want 0", i, e); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < WORDS; i++) sram[i] = {$urandom, $urandom, $urandom, $urandom};
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_reset_mid();
        test_drop_req();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
